// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared RC4 types, sizes and secret-key byte-lane order

package rc4_pkg;

    // Sizes of the S array and of the secret key
    localparam int S_DEPTH   = 256;
    localparam int KEY_BYTES = 3;
    localparam int KEY_W     = 8 * KEY_BYTES;

    // Per-iteration key-schedule FSM plus its idle/finished states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_I = 3'd1,
        LD_I = 3'd2,
        RD_J = 3'd3,
        LD_J = 3'd4,
        WR_I = 3'd5,
        WR_J = 3'd6,
        DONE = 3'd7
    } ks_state_t;

    // key[0] sits in the most significant byte lane of the packed secret key
    function automatic int key_lane_lsb(input int idx, input int nbytes);
        return (nbytes - 1 - idx) * 8;
    endfunction

endpackage

// File: rtl/rc4_key_byte_sel.sv
// rtl/rc4_key_byte_sel.sv - selects key[k] from the packed secret key

module rc4_key_byte_sel
    import rc4_pkg::*;
#(
    parameter int NBYTES = rc4_pkg::KEY_BYTES,
    parameter int KW     = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
    input  logic [8*NBYTES-1:0] key_i,
    input  logic [KW-1:0]       k_i,
    output logic [7:0]          byte_o
);

    // Plain mux over the byte lanes; out-of-range k yields zero
    always_comb begin
        byte_o = 8'h00;
        for (int b = 0; b < NBYTES; b++) begin
            if (k_i == KW'(b)) begin
                byte_o = key_i[key_lane_lsb(b, NBYTES) +: 8];
            end
        end
    end

endmodule

// File: rtl/rc4_key_schedule.sv
// rtl/rc4_key_schedule.sv - RC4 key-scheduling swap loop over the shared S RAM

module rc4_key_schedule
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = rc4_pkg::KEY_BYTES,
    parameter int S_DEPTH   = rc4_pkg::S_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [8*KEY_BYTES-1:0]     secret_key,
    output logic [$clog2(S_DEPTH)-1:0] s_address,
    output logic [7:0]                 s_data,
    output logic                       s_wren,
    input  logic [7:0]                 s_q,
    output logic                       busy,
    output logic                       done
);

    localparam int AW = $clog2(S_DEPTH);
    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [AW-1:0] I_LAST = AW'(S_DEPTH - 1);
    localparam logic [KW-1:0] K_LAST = KW'(KEY_BYTES - 1);

    ks_state_t state_q, state_d;

    logic [AW-1:0]          i_q, i_d;
    logic [AW-1:0]          j_q, j_d;
    logic [KW-1:0]          k_q, k_d;
    logic [7:0]             si_q, si_d;
    logic [7:0]             sj_q, sj_d;
    logic [8*KEY_BYTES-1:0] key_q, key_d;
    logic [7:0]             key_byte;

    rc4_key_byte_sel #(
        .NBYTES (KEY_BYTES),
        .KW     (KW)
    ) u_key_byte_sel (
        .key_i  (key_q),
        .k_i    (k_q),
        .byte_o (key_byte)
    );

    // State and loop registers; reset abandons any loop in progress
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            key_q   <= key_d;
        end
    end

    // Next state: six cycles per iteration, start only honoured when not busy
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = RD_I;
            RD_I:       state_d = LD_I;
            LD_I:       state_d = RD_J;
            RD_J:       state_d = LD_J;
            LD_J:       state_d = WR_I;
            WR_I:       state_d = WR_J;
            WR_J:       state_d = (i_q == I_LAST) ? DONE : RD_I;
            default:    state_d = IDLE;
        endcase
    end

    // Loop datapath: j accumulates mod 2^AW, k is a wrapping counter rather than i mod KEY_BYTES
    always_comb begin
        i_d   = i_q;
        j_d   = j_q;
        k_d   = k_q;
        si_d  = si_q;
        sj_d  = sj_q;
        key_d = key_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    key_d = secret_key;
                    i_d   = '0;
                    j_d   = '0;
                    k_d   = '0;
                end
            end
            LD_I: begin
                si_d = s_q;
                j_d  = j_q + AW'(s_q) + AW'(key_byte);
            end
            LD_J: begin
                sj_d = s_q;
            end
            WR_J: begin
                i_d = i_q + AW'(1);
                k_d = (k_q == K_LAST) ? '0 : k_q + KW'(1);
            end
            default: ;
        endcase
    end

    // RAM port and status decoded from registered state only
    always_comb begin
        s_address = '0;
        s_data    = 8'h00;
        s_wren    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            RD_I, LD_I: begin
                s_address = i_q;
                busy      = 1'b1;
            end
            RD_J, LD_J: begin
                s_address = j_q;
                busy      = 1'b1;
            end
            WR_I: begin
                s_address = i_q;
                s_data    = sj_q;
                s_wren    = 1'b1;
                busy      = 1'b1;
            end
            WR_J: begin
                s_address = j_q;
                s_data    = si_q;
                s_wren    = 1'b1;
                busy      = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rc4_key_schedule.sv
// tb/tb_rc4_key_schedule.sv - directed self-checking bench for rc4_key_schedule

module tb_rc4_key_schedule;

    typedef logic [7:0] sarr_t [256];

    logic        clk;
    logic        reset;
    logic        start;
    logic [23:0] secret_key;
    logic [7:0]  s_address;
    logic [7:0]  s_data;
    logic        s_wren;
    logic [7:0]  s_q;
    logic        busy;
    logic        done;

    sarr_t mem;
    sarr_t pre;
    sarr_t ident;
    sarr_t expect_s;
    sarr_t snap;
    logic  load;

    int n_run;
    int n_fail;
    int cyc;

    rc4_key_schedule dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .secret_key (secret_key),
        .s_address  (s_address),
        .s_data     (s_data),
        .s_wren     (s_wren),
        .s_q        (s_q),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // S RAM model: registered address, one-cycle read latency, bulk preload
    always @(posedge clk) begin
        if (load) begin
            for (int a = 0; a < 256; a++) mem[a] <= pre[a];
        end else if (s_wren) begin
            mem[s_address] <= s_data;
        end
        s_q <= mem[s_address];
    end

    // Reference key schedule
    function automatic sarr_t ksa(input sarr_t s0, input logic [23:0] key);
        sarr_t      s;
        logic [7:0] j;
        logic [7:0] t;
        logic [7:0] kb;
        s = s0;
        j = 8'h00;
        for (int i = 0; i < 256; i++) begin
            kb   = 8'(key >> (8 * (2 - (i % 3))));
            j    = j + s[i] + kb;
            t    = s[i];
            s[i] = s[j];
            s[j] = t;
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_s(input sarr_t v);
        pre  = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
    endtask

    // Present start for one edge; cyc=0 is the first RD_I cycle
    task automatic go(input logic [23:0] key);
        start      = 1'b1;
        secret_key = key;
        @(negedge clk);
        start      = 1'b0;
        secret_key = 24'hDEAD00;
        cyc        = 0;
    endtask

    task automatic adv_to(input int n);
        while (cyc < n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Run until done (bounded), optionally pulsing start at a given busy cycle
    task automatic finish_run(input int pulse_at);
        while (!done && cyc < 2000) begin
            start = (cyc == pulse_at);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic compare_s(input string tag, input sarr_t exp);
        int bad;
        bad = 0;
        for (int a = 0; a < 256; a++) if (mem[a] !== exp[a]) bad++;
        check(tag, bad, 0);
    endtask

    initial begin
        n_run      = 0;
        n_fail     = 0;
        cyc        = 0;
        reset      = 1'b0;
        start      = 1'b0;
        secret_key = 24'h0;
        load       = 1'b0;
        for (int a = 0; a < 256; a++) ident[a] = 8'(a);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_addr", s_address, 0);
        check("rst_data", s_data, 0);
        check("rst_wren", s_wren, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b1;
        @(negedge clk);

        // Key 0x000000: iteration-level checks and exact loop length
        load_s(ident);
        go(24'h000000);
        check("k0_busy_c0", busy, 1);
        check("k0_addr_c0", s_address, 0);
        adv_to(4);
        check("k0_wri_wren", s_wren, 1);
        check("k0_wri_addr", s_address, 0);
        check("k0_wri_data", s_data, 0);
        adv_to(5);
        check("k0_wrj_wren", s_wren, 1);
        check("k0_wrj_addr", s_address, 0);
        adv_to(6);
        check("k0_it0_s0", mem[0], 8'h00);
        adv_to(12);
        check("k0_it1_s1", mem[1], 8'h01);
        adv_to(18);
        check("k0_it2_s2", mem[2], 8'h03);
        check("k0_it2_s3", mem[3], 8'h02);
        adv_to(1535);
        check("k0_busy_1535", busy, 1);
        check("k0_done_1535", done, 0);
        finish_run(-1);
        check("k0_done_cyc", cyc, 1536);
        check("k0_busy_end", busy, 0);
        check("k0_wren_end", s_wren, 0);
        compare_s("k0_final", ksa(ident, 24'h000000));

        // Key 0x000001: iteration 2 swaps s[2] and s[4]
        load_s(ident);
        go(24'h000001);
        adv_to(18);
        check("k1_it2_s2", mem[2], 8'h04);
        check("k1_it2_s4", mem[4], 8'h02);
        finish_run(-1);
        check("k1_done_cyc", cyc, 1536);
        compare_s("k1_final", ksa(ident, 24'h000001));

        // Start pulsed while busy is ignored
        load_s(ident);
        go(24'h000001);
        finish_run(100);
        check("pulse_done_cyc", cyc, 1536);
        compare_s("pulse_final", ksa(ident, 24'h000001));

        // Reset mid-loop clears outputs at once; a clean rerun then matches the model
        load_s(ident);
        go(24'hA5C3F0);
        adv_to(700);
        reset = 1'b0;
        #1;
        check("mid_rst_addr", s_address, 0);
        check("mid_rst_data", s_data, 0);
        check("mid_rst_wren", s_wren, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        load_s(ident);
        go(24'hA5C3F0);
        finish_run(-1);
        check("rerun_done_cyc", cyc, 1536);
        compare_s("rerun_final", ksa(ident, 24'hA5C3F0));

        // Back-to-back: start held in DONE restarts on the next edge with the new key
        for (int a = 0; a < 256; a++) snap[a] = mem[a];
        expect_s = ksa(snap, 24'h0F1E2D);
        start      = 1'b1;
        secret_key = 24'h0F1E2D;
        @(negedge clk);
        check("b2b_busy", busy, 1);
        check("b2b_done", done, 0);
        check("b2b_addr", s_address, 0);
        start      = 1'b0;
        secret_key = 24'h000000;
        cyc        = 0;
        finish_run(-1);
        check("b2b_done_cyc", cyc, 1536);
        compare_s("b2b_final", expect_s);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/rc4_key_schedule.md
# rc4_key_schedule

RC4 key-scheduling stage. It runs after the S-memory initialisation stage has loaded s[i]=i for i=0..255. It performs the 256-iteration swap loop `j = j + s[i] + key[i mod 3]; swap(s[i], s[j])` in place on the shared 256x8 S RAM, using the 24-bit secret key. The top level gives this block the S RAM port while `busy` is high. The permuted S array it leaves behind is consumed by the decryption stage.

## Interface
Parameters:
- KEY_BYTES, 3, number of secret-key bytes; the index `i mod KEY_BYTES` wraps at this value.
- S_DEPTH, 256, number of S entries; the loop index runs 0..S_DEPTH-1.

Ports:
- clk  input  1  system clock (CLOCK_50).
- reset  input  1  asynchronous, active-low reset.
- start  input  1  active-high request. Accepted on a rising clk edge when in IDLE or DONE.
- secret_key  input  24  key; captured on start acceptance.
  - key[0]=secret_key[23:16]
  - key[1]=secret_key[15:8]
  - key[2]=secret_key[7:0]
- s_address  output  8  S RAM address.
- s_data  output  8  S RAM write data.
- s_wren  output  1  S RAM write enable.
- s_q  input  8  S RAM read data. The RAM registers the address; s_q is valid in the cycle after the address is driven.
- busy  output  1  high from start acceptance until the loop completes.
- done  output  1  high in DONE; held until the next start is accepted or reset.

## Operation
- Loop registers: i (8b), j (8b), k (key index, 0..2), si, sj (8b each), latched key (24b).
- Per-iteration FSM, six states:
  - RD_I: s_address=i.
  - LD_I: si<=s_q; j<=j+s_q+key[k].
  - RD_J: s_address=j.
  - LD_J: sj<=s_q.
  - WR_I: s_address=i, s_data=sj, s_wren=1.
  - WR_J: s_address=j, s_data=si, s_wren=1. Also i<=i+1 and k<=(k==2)?0:k+1. If i==255, go to DONE; else go to RD_I.
- IDLE/DONE with start=1: latch the key, clear i, j and k to 0, set busy=1, done=0, go to RD_I.
- All arithmetic is mod 256: 8-bit adds with the carry discarded. i wraps only at loop exit. k uses an explicit counter, not a divider.
- i==j: both writes hit the same address with the same value; the result is correct.
- start while busy: ignored. secret_key changes while busy: ignored.
- reset asserted mid-loop: return to IDLE immediately with all outputs cleared. S is left partially permuted, so the top must rerun initialisation before restarting.
- s_wren is high only in WR_I and WR_J.

## Timing
- Reset values: s_address=0, s_data=0, s_wren=0, busy=0, done=0. The FSM is in IDLE.
- All outputs are registered or decoded directly from state registers. There is no combinational path from any input to any output.
- The accepting edge moves the FSM to RD_I; busy is high from that cycle on.
- Each iteration takes exactly 6 cycles; the full loop takes 1536 cycles.
- done rises and busy falls 1536 cycles after the first RD_I cycle. In DONE, s_wren=0.
- A read issued in RD_x returns data sampled at the end of LD_x (one-cycle RAM latency). There are no wait states.

## Structure
- Shared package rc4_pkg holds:
  - the state enum (IDLE, RD_I, LD_I, RD_J, LD_J, WR_I, WR_J, DONE);
  - S_DEPTH, KEY_BYTES and the byte-lane order of the secret key, which the decryption stage also uses.
- Sub-module rc4_key_byte_sel: selects key[k] from the 24-bit key (combinational mux, MSB byte first).
- The top level muxes the S RAM port between the initialisation stage, this block and later stages, based on the done/busy signals.

## Test plan
- S preloaded with the identity, key=0x000000, start pulse:
  - After iteration 0: s[0]=0.
  - After iteration 1: j=1, no change.
  - After iteration 2: j=3, s[2]=3, s[3]=2.
  - done asserts exactly 1536 cycles after the first RD_I.
- Identity S, key=0x000001: iteration 2 gives j=4, swapping s[2] and s[4]. The final S matches a reference model over all 256 entries.
- i==j case, identity S, key=0x000000, iteration 0: two writes of 0x00 to address 0; s[0] stays 0.
- start pulsed at cycle 100 of busy: ignored; the final S and done timing are identical to the unpulsed run.
- reset asserted at cycle 700: all outputs are 0 the same cycle. After re-initialisation and start, the result matches a clean run.
- Back-to-back runs with start held in DONE: the second run begins on the next edge with i=j=k=0 and the newly latched key.
